instruction_fetch: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, reads the instruction memory, and drives the IF/ID pipeline register that feeds `instruction_decode` (`o_instruction` → `i_instruction`, `o_pcounter4` → `i_pcounter4`). It also provides debug control:
- the instruction memory is loaded while the stage is idle;
- the program then runs continuously or single-steps;
- fetching the HALT word stops the stage.

---
 rtl/mips_pkg.sv | 15 +
 rtl/instruction_memory.sv | 22 ++
 rtl/instruction_fetch.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and fetch-state encoding for the MIPS pipeline.
package mips_pkg;

    localparam int NB_DATA = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed store with asynchronous read and synchronous write.
module instruction_memory #(
    parameter int NB_DATA      = 32,
    parameter int NB_IMEM_ADDR = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [NB_IMEM_ADDR-1:0] waddr,
    input  logic [NB_DATA-1:0]      wdata,
    input  logic [NB_IMEM_ADDR-1:0] raddr,
    output logic [NB_DATA-1:0]      rdata
);

    logic [NB_DATA-1:0] mem [2**NB_IMEM_ADDR];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, next-PC mux, debug run/step/halt FSM and IF/ID register.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int NB_DATA      = mips_pkg::NB_DATA,
    parameter int NB_IMEM_ADDR = 8
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_stall,
    input  logic                    i_jump,
    input  logic [NB_DATA-1:0]      i_jump_addr,
    input  logic                    i_branch_taken,
    input  logic [NB_DATA-1:0]      i_branch_addr,
    input  logic                    i_start,
    input  logic                    i_step,
    input  logic                    i_load_we,
    input  logic [NB_IMEM_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0]      i_load_data,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_DATA-1:0]      o_pcounter4,
    output logic                    o_valid,
    output logic [NB_DATA-1:0]      o_pc,
    output logic                    o_halted,
    output logic                    o_idle
);

    fetch_state_t       state, state_next;
    logic [NB_DATA-1:0] pc, pc_next, pc4, target, word;
    logic [NB_DATA-1:0] instr_q, instr_next, pc4_q, pc4_next;
    logic               valid_q, valid_next;
    logic               active, fetch, redirect, halt_hit;

    instruction_memory #(
        .NB_DATA      (NB_DATA),
        .NB_IMEM_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .clk   (clk),
        .we    (i_load_we && state == ST_IDLE),
        .waddr (i_load_addr),
        .wdata (i_load_data),
        .raddr (pc[NB_IMEM_ADDR+1:2]),
        .rdata (word)
    );

    assign active   = state == ST_RUN || state == ST_STEP;
    assign fetch    = active && !i_stall;
    assign redirect = i_jump || i_branch_taken;
    assign pc4      = pc + NB_DATA'(4);
    assign target   = i_jump ? {i_jump_addr[NB_DATA-1:2], 2'b00} : {i_branch_addr[NB_DATA-1:2], 2'b00};
    // A redirect squashes the word fetched alongside it, so a HALT word there never executes.
    assign halt_hit = fetch && !redirect && word == NB_DATA'(HALT_INSTR);

    always_comb begin
        pc_next    = pc;
        instr_next = NB_DATA'(NOP_INSTR);
        pc4_next   = '0;
        valid_next = 1'b0;
        if (active && i_stall) begin
            instr_next = instr_q;
            pc4_next   = pc4_q;
            valid_next = valid_q;
        end else if (fetch && redirect) begin
            pc_next    = target;
        end else if (fetch && !halt_hit) begin
            pc_next    = pc4;
            instr_next = word;
            pc4_next   = pc4;
            valid_next = 1'b1;
        end
        state_next = state == ST_IDLE ? (i_start ? ST_RUN : i_step ? ST_STEP : ST_IDLE) :
                     halt_hit ? ST_HALT :
                     (state == ST_STEP && fetch) ? ST_IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            pc      <= '0;
            instr_q <= NB_DATA'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            instr_q <= instr_next;
            pc4_q   <= pc4_next;
            valid_q <= valid_next;
        end
    end

    assign o_instruction = instr_q;
    assign o_pcounter4   = pc4_q;
    assign o_valid       = valid_q;
    assign o_pc          = pc;
    assign o_halted      = state == ST_HALT;
    assign o_idle        = state == ST_IDLE;

endmodule
